// File: rtl/alarm_ring_controller_if.sv
// Signal bundle between the alarm sequencer and its surroundings (comparator, buttons, buzzer, datapath).
interface alarm_ring_controller_if;
  logic       AA;
  logic       MinTick;
  logic       Snooze;
  logic       Stop;
  logic       Mute;
  logic       Sound;
  logic       Ringing;
  logic       Snoozing;
  logic       EN_SNZ;
  logic       EN_STOP;
  logic [3:0] SnoozeLeft;
  logic [2:0] SnzUsed;

  modport master (
    output AA, MinTick, Snooze, Stop, Mute,
    input  Sound, Ringing, Snoozing, EN_SNZ, EN_STOP, SnoozeLeft, SnzUsed
  );

  modport slave (
    input  AA, MinTick, Snooze, Stop, Mute,
    output Sound, Ringing, Snoozing, EN_SNZ, EN_STOP, SnoozeLeft, SnzUsed
  );
endinterface

// File: rtl/alarm_ring_controller.sv
// Audible-phase sequencer for the alarm: ring, snooze countdown, snooze limit,
// unattended-ring timeout and one-cycle snooze/stop enables to the datapath.
module alarm_ring_controller #(
  parameter int unsigned SNOOZE_MIN       = 9,
  parameter int unsigned RING_TIMEOUT_MIN = 5,
  parameter int unsigned MAX_SNOOZES      = 3
) (
  input  logic                          Clk,
  input  logic                          Clr,
  alarm_ring_controller_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam logic [3:0] SnoozeLoad  = 4'(SNOOZE_MIN);
  localparam logic [3:0] RingLastMin = 4'(RING_TIMEOUT_MIN - 1);
  localparam logic [2:0] SnzLimit    = 3'(MAX_SNOOZES);

  state_e     state_q;
  logic [3:0] ring_min_q;
  logic [3:0] snz_left_q;
  logic [2:0] snz_used_q;
  logic       en_snz_q;
  logic       en_stop_q;
  logic       aa_p_q;
  logic       snz_p_q;
  logic       stp_p_q;

  logic aa_edge;
  logic snz_edge;
  logic stp_edge;

  assign aa_edge  = bus.AA     & ~aa_p_q;
  assign snz_edge = bus.Snooze & ~snz_p_q;
  assign stp_edge = bus.Stop   & ~stp_p_q;

  // Previous values reset high so a level already asserted at reset never counts as an edge.
  always_ff @(posedge Clk) begin
    if (!Clr) begin
      state_q    <= IDLE;
      ring_min_q <= '0;
      snz_left_q <= '0;
      snz_used_q <= '0;
      en_snz_q   <= 1'b0;
      en_stop_q  <= 1'b0;
      aa_p_q     <= 1'b1;
      snz_p_q    <= 1'b1;
      stp_p_q    <= 1'b1;
    end else begin
      aa_p_q    <= bus.AA;
      snz_p_q   <= bus.Snooze;
      stp_p_q   <= bus.Stop;
      en_snz_q  <= 1'b0;
      en_stop_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (aa_edge) begin
            state_q    <= RING;
            ring_min_q <= '0;
            snz_used_q <= '0;
          end
        end
        RING: begin
          // A snooze edge at the limit falls through, so a coincident tick still counts.
          if (stp_edge) begin
            state_q   <= HOLD;
            en_stop_q <= 1'b1;
          end else if (snz_edge && (snz_used_q < SnzLimit)) begin
            state_q    <= SNOOZE;
            snz_left_q <= SnoozeLoad;
            snz_used_q <= snz_used_q + 3'd1;
            en_snz_q   <= 1'b1;
          end else if (bus.MinTick) begin
            if (ring_min_q == RingLastMin) begin
              state_q <= HOLD;
            end else begin
              ring_min_q <= ring_min_q + 4'd1;
            end
          end
        end
        SNOOZE: begin
          if (stp_edge) begin
            state_q    <= HOLD;
            en_stop_q  <= 1'b1;
            snz_left_q <= '0;
          end else if (bus.MinTick) begin
            if (snz_left_q == 4'd1) begin
              state_q    <= RING;
              ring_min_q <= '0;
              snz_left_q <= '0;
            end else begin
              snz_left_q <= snz_left_q - 4'd1;
            end
          end
        end
        HOLD: begin
          // Wait out the matching minute so the same alarm cannot re-trigger.
          if (!bus.AA) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Ringing    = (state_q == RING);
  assign bus.Snoozing   = (state_q == SNOOZE);
  assign bus.Sound      = (state_q == RING) & ~bus.Mute;
  assign bus.EN_SNZ     = en_snz_q;
  assign bus.EN_STOP    = en_stop_q;
  assign bus.SnoozeLeft = snz_left_q;
  assign bus.SnzUsed    = snz_used_q;

endmodule

// File: doc/alarm_ring_controller.md
# alarm_ring_controller

Sequences the alarm's audible phase for the alarm clock: decides when the buzzer sounds, runs the snooze countdown, enforces the snooze limit and an automatic ring timeout, and issues the snooze/stop enables to the datapath. It sits between the alarm-match comparator output and the sound driver, taking its place alongside the main control unit. It is clocked by the divided system clock `Clk`. Button inputs are debounced, synchronized levels.

## Interface
- `SNOOZE_MIN`, default 9: snooze length in minutes, 1..15.
- `RING_TIMEOUT_MIN`, default 5: minutes of unattended ringing before auto-silence, 1..15.
- `MAX_SNOOZES`, default 3: snoozes allowed per alarm event, 0..7.

- `Clk` input 1: single clock, rising-edge.
- `Clr` input 1: reset, synchronous, active-low.
- `AA` input 1: alarm match level, high while current time equals an enabled alarm.
- `MinTick` input 1: one-cycle pulse at each minute rollover.
- `Snooze`, `Stop` inputs 1 each: button levels; only rising edges act.
- `Mute` input 1: level; silences `Sound` without changing state.
- `Sound` output 1: buzzer enable.
- `Ringing`, `Snoozing` outputs 1 each: state flags.
- `EN_SNZ`, `EN_STOP` outputs 1 each: one-cycle pulses to the datapath.
- `SnoozeLeft` output 4: remaining snooze minutes. It is 0 outside SNOOZE.
- `SnzUsed` output 3: snoozes consumed in the current event.

## Operation
- Edge detection uses registered previous values `AA_p`, `Snz_p` and `Stp_p`.
  - An edge is `X & ~X_p`.
  - Reset sets all three previous values to 1. A level already high at reset does not trigger.
- There are four states, encoded in 2 bits: IDLE, RING, SNOOZE and HOLD.
- IDLE:
  - An `AA` edge moves to RING, clears `ring_min` and clears `SnzUsed`.
- RING:
  - Transition priority is Stop edge > Snooze edge > timeout.
  - Stop edge: go to HOLD and pulse `EN_STOP`.
  - Snooze edge with `SnzUsed < MAX_SNOOZES`:
    - go to SNOOZE;
    - load `SnoozeLeft = SNOOZE_MIN`;
    - increment `SnzUsed`;
    - pulse `EN_SNZ`.
  - Snooze edge with `SnzUsed == MAX_SNOOZES`: ignored, no pulse.
  - `MinTick`:
    - If `ring_min == RING_TIMEOUT_MIN-1`, go to HOLD. No `EN_STOP` pulse.
    - Otherwise increment `ring_min`.
- SNOOZE:
  - Stop edge: go to HOLD, pulse `EN_STOP`, clear `SnoozeLeft`. Stop has priority over `MinTick`.
  - `MinTick` with `SnoozeLeft == 1`: go to RING, clear `ring_min`, clear `SnoozeLeft`.
  - `MinTick` otherwise: decrement `SnoozeLeft`.
  - Snooze edges are ignored.
- HOLD:
  - Go to IDLE in the first cycle `AA == 0`. This prevents re-triggering within the matching minute.
  - Edges are ignored.
- `AA` edges outside IDLE are ignored. An alarm re-match during snooze does not restart the event.
- Counter widths:
  - `ring_min` is 4 bits.
  - `SnoozeLeft` is 4 bits.
  - `SnzUsed` is 3 bits and saturates at `MAX_SNOOZES`. It is never wrapped.
- `Sound = Ringing & ~Mute`. This is combinational from the state register and `Mute`. Toggling `Mute` has no effect on the timeout count.
- `Ringing = (state == RING)`.
- `Snoozing = (state == SNOOZE)`.

## Timing
- All state, counters and pulses are registered.
- A qualifying input sampled at rising edge N is reflected in outputs after edge N. Latency is 1 cycle.
- `EN_SNZ` and `EN_STOP` are high for exactly one cycle, the cycle after the triggering edge.
- A button held high produces one action only. A new action requires a low cycle first.
- Snooze and Stop rising in the same cycle: Stop wins and only `EN_STOP` pulses.
- `MinTick` coincident with a Snooze edge in RING: the Snooze transition is taken and the tick is discarded.
- `MinTick` coincident with an `AA` edge in IDLE: enter RING with `ring_min = 0`. The tick does not count.
- Reset values, applied at any rising edge with `Clr = 0`, including mid-ring or mid-snooze:
  - state IDLE;
  - `Sound`, `Ringing`, `Snoozing`, `EN_SNZ` and `EN_STOP` all 0;
  - `SnoozeLeft`, `SnzUsed` and `ring_min` all 0;
  - `AA_p`, `Snz_p` and `Stp_p` all 1.
- `Clr` overrides every other input in the same cycle.

## Test plan
- **Basic ring and stop.**
  - Stimulus: `AA` rises, `Mute = 0`, then a Stop edge 10 cycles later, with `AA` still high.
  - Response: `Sound = 1` from the next cycle; one `EN_STOP` pulse; HOLD while `AA` is high; IDLE one cycle after `AA` falls; no re-ring.
- **Snooze cycle with default parameters.**
  - Stimulus: ring, then a Snooze edge, then 9 `MinTick` pulses.
  - Response: `EN_SNZ` pulses once; `SnoozeLeft` goes 9→8…→1; after the 9th tick `Ringing = 1` and `SnzUsed = 1`.
- **Snooze limit.**
  - Stimulus: repeat snooze and expiry 3 times, then a 4th Snooze edge.
  - Response: the 4th edge is ignored; no `EN_SNZ`; `Ringing` stays 1; `SnzUsed = 3`.
- **Timeout and mute.**
  - Stimulus: ring with `Mute = 1`, then 5 `MinTick` pulses.
  - Response: `Sound = 0` but `Ringing = 1` throughout; HOLD after the 5th tick; no `EN_STOP`.
- **Simultaneous and held inputs.**
  - Stimulus: Snooze and Stop rise together in RING; separately, Snooze held high for 20 cycles.
  - Response: only `EN_STOP` pulses in the first case; a single `EN_SNZ` in the second.
- **Reset mid-snooze and reset with `AA` high.**
  - Stimulus: `Clr = 0` for one cycle with `SnoozeLeft = 5`.
  - Response: all outputs 0 and state IDLE; with `AA` held high through release, no ring until `AA` falls and rises again.
